// File: rtl/zombie_pkg.sv
// zombie_pkg
// Shared types and constants for the zombie wave game sequencer.
//   state_t     : top-level game state (IDLE/LOAD/PLAY/OVER)
//   LIVES_INIT  : lives granted at the start of every game
//   LFSR_TAPS   : feedback tap mask for x^8+x^6+x^5+x^4+1
//   SCORE_MAX   : score saturation value
//   LOAD_SHIFTS : number of shifts needed to fill every slot
//   shift_in()  : pushes a new column into the top slot of a packed slot vector
package zombie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [1:0] LIVES_INIT  = 2'd3;
  localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;
  localparam logic [7:0] SCORE_MAX   = 8'hFF;
  localparam logic [2:0] LOAD_SHIFTS = 3'd4;

  // Slot 0 lives in [7:6] and slot 3 in [1:0], so moving every zombie one
  // slot down is a right shift by one 2-bit field with the new column on top.
  function automatic logic [7:0] shift_in(input logic [7:0] slots,
                                          input logic [1:0] col);
    return {col, slots[7:2]};
  endfunction

endpackage

// File: rtl/zombie_wave_controller_lfsr8.sv
// lfsr8
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Shifts on every rising edge of clk_div regardless of game state.
//   clk_div : divided system clock
//   reset   : asynchronous, active-high; loads SEED
//   q       : current LFSR value
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_div,
  input  logic       reset,
  output logic [7:0] q
);
  import zombie_pkg::*;

  logic feedback;

  // XOR of the tapped bits (7,5,4,3) shifted into the LSB.
  assign feedback = ^(q & LFSR_TAPS);

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      q <= SEED;
    end else begin
      q <= {q[6:0], feedback};
    end
  end

endmodule

// File: rtl/zombie_wave_controller.sv
// zombie_wave_controller
// Game sequencer feeding the dot-matrix displayer. Holds four zombie column
// positions (slots), advances them on a programmable tick, injects a
// pseudo-random column at the top, resolves hits against the bottom slot and
// tracks score and lives.
//   clk_div   : divided system clock, all state changes on its rising edge
//   reset     : asynchronous, active-high
//   start     : pulse, begins a game from IDLE or OVER
//   hit_valid : pulse, player fired at hit_col
//   hit_col   : column fired at (0 = leftmost pair)
//   place     : slot positions, [7:6] top slot 0 ... [1:0] bottom slot 3
//   flag      : displayer blank/clear, low only while playing
//   score     : zombies killed, saturating at 255
//   lives     : remaining lives
//   game_over : high once the last life is lost
module zombie_wave_controller #(
  parameter int         STEP_TICKS = 50,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic       start,
  input  logic       hit_valid,
  input  logic [1:0] hit_col,
  output logic [7:0] place,
  output logic       flag,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);
  import zombie_pkg::*;

  localparam int CNT_W = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] STEP_FIRST = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] step_cnt_reg;
  logic [2:0]       load_cnt_reg;

  logic [7:0] lfsr_q;
  logic [1:0] new_col;
  logic [5:0] lfsr_unused;
  logic       hit;
  logic       expiry;
  logic       life_lost;
  logic [1:0] lives_dec;
  logic [7:0] score_inc;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_div (clk_div),
    .reset   (reset),
    .q       (lfsr_q)
  );

  // Only the two LSBs pick a column; the upper bits just keep the sequence long.
  assign new_col     = lfsr_q[1:0];
  assign lfsr_unused = lfsr_q[7:2];

  assign hit       = hit_valid && (hit_col == place[1:0]);
  assign expiry    = (step_cnt_reg == STEP_LAST);
  // A miss and an expiry in the same cycle cost a single life.
  assign life_lost = hit_valid || expiry;
  assign lives_dec = lives - 2'd1;
  assign score_inc = (score == SCORE_MAX) ? score : score + 8'd1;

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      place        <= 8'h00;
      flag         <= 1'b1;
      score        <= 8'h00;
      lives        <= 2'd0;
      game_over    <= 1'b0;
      step_cnt_reg <= '0;
      load_cnt_reg <= 3'd0;
    end else begin
      case (state_reg)
        IDLE, OVER: begin
          if (start) begin
            score        <= 8'h00;
            lives        <= LIVES_INIT;
            game_over    <= 1'b0;
            load_cnt_reg <= 3'd0;
            step_cnt_reg <= '0;
            state_reg    <= LOAD;
          end
        end

        LOAD: begin
          if (load_cnt_reg == LOAD_SHIFTS) begin
            // The cycle that enters PLAY already counts as the first tick of
            // the first step, so the first zombie arrives STEP_TICKS-1 edges
            // after flag falls and every later one STEP_TICKS apart.
            state_reg    <= PLAY;
            flag         <= 1'b0;
            step_cnt_reg <= STEP_FIRST;
          end else begin
            place        <= shift_in(place, new_col);
            load_cnt_reg <= load_cnt_reg + 3'd1;
          end
        end

        PLAY: begin
          if (hit) begin
            score        <= score_inc;
            place        <= shift_in(place, new_col);
            step_cnt_reg <= '0;
          end else begin
            if (life_lost) begin
              lives <= lives_dec;
            end
            if (expiry) begin
              place        <= shift_in(place, new_col);
              step_cnt_reg <= '0;
            end else begin
              step_cnt_reg <= step_cnt_reg + CNT_W'(1);
            end
            if (life_lost && (lives_dec == 2'd0)) begin
              state_reg <= OVER;
              flag      <= 1'b1;
              game_over <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zombie_wave_controller.sv
// tb_zombie_wave_controller
// Scoreboard bench: the stimulus process updates an expected view of the
// outputs after every edge and queues a record whenever that view changes;
// the monitor pops and compares each time the DUT outputs change.
module tb_zombie_wave_controller;

  localparam int         ST   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_OVER = 3;

  logic       clk_div = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       hit_valid = 1'b0;
  logic [1:0] hit_col = 2'd0;
  logic [7:0] place;
  logic       flag;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  zombie_wave_controller #(
    .STEP_TICKS (ST),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk_div   (clk_div),
    .reset     (reset),
    .start     (start),
    .hit_valid (hit_valid),
    .hit_col   (hit_col),
    .place     (place),
    .flag      (flag),
    .score     (score),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int         cyc;
    int         phase;
    logic [7:0] place;
    logic       flag;
    logic [7:0] score;
    logic [1:0] lives;
    logic       over;
  } rec_t;

  rec_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   phase = 0;
  int   lfsr_base = 0;
  logic [7:0] lfsr_tab [0:1023];

  // expected view
  int         m_state;
  logic [7:0] m_place;
  logic [7:0] m_score;
  logic       m_flag;
  logic       m_over;
  logic [1:0] m_lives;
  int         m_load;
  int         m_deadline;
  logic [19:0] last_key;

  task automatic tick();
    @(posedge clk_div);
    #1;
    cyc++;
  endtask

  task automatic push_rec();
    rec_t r;
    r.cyc = cyc; r.phase = phase; r.place = m_place; r.flag = m_flag;
    r.score = m_score; r.lives = m_lives; r.over = m_over;
    sb_q.push_back(r);
    last_key = {m_place, m_flag, m_score, m_lives, m_over};
  endtask

  task automatic push_exp();
    if ({m_place, m_flag, m_score, m_lives, m_over} !== last_key) push_rec();
  endtask

  task automatic m_reset();
    m_state = M_IDLE; m_place = 8'h00; m_flag = 1'b1; m_score = 8'h00;
    m_lives = 2'd0; m_over = 1'b0; m_load = 0; m_deadline = 0;
  endtask

  // New column at edge k is the LFSR value held before that edge.
  task automatic m_shift();
    logic [7:0] v;
    v = lfsr_tab[cyc - 1 - lfsr_base];
    m_place = {v[1:0], m_place[7:2]};
  endtask

  task automatic step(input logic st, input logic hv, input logic [1:0] hc);
    logic due;
    start = st; hit_valid = hv; hit_col = hc;
    tick();
    start = 1'b0; hit_valid = 1'b0; hit_col = 2'd0;
    case (m_state)
      M_IDLE, M_OVER: begin
        if (st) begin
          m_score = 8'h00; m_lives = 2'd3; m_over = 1'b0;
          m_load = 0; m_state = M_LOAD;
        end
      end
      M_LOAD: begin
        if (m_load < 4) begin
          m_shift();
          m_load++;
        end else begin
          m_state = M_PLAY; m_flag = 1'b0; m_deadline = cyc + ST - 1;
        end
      end
      default: begin
        if (hv && hc == m_place[1:0]) begin
          if (m_score != 8'hFF) m_score = m_score + 8'd1;
          m_shift();
          m_deadline = cyc + ST;
        end else begin
          due = (cyc == m_deadline);
          if (hv || due) m_lives = m_lives - 2'd1;
          if (due) begin
            m_shift();
            m_deadline = cyc + ST;
          end
          if (m_lives == 2'd0) begin
            m_state = M_OVER; m_flag = 1'b1; m_over = 1'b1;
          end
        end
      end
    endcase
    push_exp();
  endtask

  // monitor
  logic [19:0] mon_prev = 'x;
  logic [19:0] mon_cur;
  rec_t        mon_r;
  always @(negedge clk_div) begin
    mon_cur = {place, flag, score, lives, game_over};
    if (mon_cur !== mon_prev) begin
      mon_prev = mon_cur;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got place=%h flag=%b score=%0d lives=%0d over=%b, want no change",
                 cyc, place, flag, score, lives, game_over);
      end else begin
        mon_r = sb_q.pop_front();
        if (mon_r.cyc != cyc || place !== mon_r.place || flag !== mon_r.flag ||
            score !== mon_r.score || lives !== mon_r.lives || game_over !== mon_r.over) begin
          bad++;
          $display("FAIL phase%0d_event cyc got=%0d want=%0d place got=%h want=%h flag got=%b want=%b score got=%0d want=%0d lives got=%0d want=%0d over got=%b want=%b",
                   mon_r.phase, cyc, mon_r.cyc, place, mon_r.place, flag, mon_r.flag,
                   score, mon_r.score, lives, mon_r.lives, game_over, mon_r.over);
        end else begin
          $display("ev phase%0d cyc=%0d place=%h flag=%b score=%0d lives=%0d over=%b ok",
                   mon_r.phase, cyc, place, flag, score, lives, game_over);
        end
      end
    end
  end

  initial begin
    lfsr_tab[0] = SEED;
    for (int i = 1; i < 1024; i++) begin
      lfsr_tab[i] = {lfsr_tab[i-1][6:0],
                     lfsr_tab[i-1][7] ^ lfsr_tab[i-1][5] ^ lfsr_tab[i-1][4] ^ lfsr_tab[i-1][3]};
    end
    m_reset();
    push_rec();                     // reset state seen at the first sample
    repeat (2) @(posedge clk_div);
    #1 reset = 1'b0;
    cyc = 0; lfsr_base = 0;

    // idle: nothing moves without start
    phase = 1;
    repeat (3) step(1'b0, 1'b0, 2'd0);

    // game with no hits; start pulses in LOAD and PLAY must be ignored
    phase = 2;
    step(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 40 && m_state != M_OVER; i++) begin
      step((i == 1) || (i == 6), 1'b0, 2'd0);
    end

    // restart from OVER, hit, auto-advance, miss on expiry, plain miss
    phase = 3;
    step(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 10 && m_state != M_PLAY; i++) step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, m_place[1:0]);
    repeat (ST) step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 20 && (cyc + 1) != m_deadline; i++) step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, m_place[1:0] + 2'd1);
    step(1'b0, 1'b1, m_place[1:0] ^ 2'b01);
    step(1'b0, 1'b0, 2'd0);

    // score saturation: 256 consecutive correct hits
    phase = 4;
    step(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 10 && m_state != M_PLAY; i++) step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, m_place[1:0]);
    step(1'b0, 1'b0, 2'd0);

    // asynchronous reset mid-PLAY, then a fresh game from the reseeded LFSR
    phase = 5;
    reset = 1'b1;
    m_reset();
    if (sb_q.size() > 0 && sb_q[$].cyc == cyc) void'(sb_q.pop_back());
    push_rec();
    tick();
    reset = 1'b0;
    lfsr_base = cyc;
    step(1'b1, 1'b0, 2'd0);
    repeat (7) step(1'b0, 1'b0, 2'd0);

    @(negedge clk_div);
    #1;
    while (sb_q.size() > 0) begin
      mon_r = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL phase%0d_missing got no change want change at cyc=%0d place=%h",
               mon_r.phase, mon_r.cyc, mon_r.place);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
